// File: rtl/elevator_ctrl.sv
// Elevator car controller: latches floor requests and runs collective (SCAN) scheduling with hop and door timing.
// Requests act on the edge they are sampled; each hop takes TRAVEL_CYCLES, each stop holds the door DOOR_CYCLES.
module elevator_ctrl #(
  parameter int NUM_FLOORS    = 8,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] req,
  input  logic [2:0]            next_floor,
  output logic [2:0]            floor,
  output logic                  mux_sig,
  output logic                  moving,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] DOOR_LOAD   = DW'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [2:0]              floor_q, floor_d;
  logic                    dir_q, dir_d;
  logic [TW-1:0]           travel_tmr_q, travel_tmr_d;
  logic [DW-1:0]           door_tmr_q, door_tmr_d;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d;

  logic [NUM_FLOORS-1:0]   cur_oh, nxt_oh, req_m, eff, clr;
  logic                    hit_cur, hit_nxt;
  logic                    above_cur, below_cur, above_nxt, below_nxt;

  function automatic logic [NUM_FLOORS-1:0] onehot(input logic [2:0] f);
    logic [NUM_FLOORS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (3'(i) == f) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [2:0] f);
    logic [NUM_FLOORS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (3'(i) > f) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [2:0] f);
    logic [NUM_FLOORS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (3'(i) < f) v[i] = 1'b1;
    end
    return v;
  endfunction

  // A call for the floor whose door is already open is satisfied by that stop.
  assign cur_oh    = onehot(floor_q);
  assign nxt_oh    = onehot(next_floor);
  assign req_m     = (state_q == DOOR) ? (req & ~cur_oh) : req;
  assign eff       = pending_q | req_m;

  assign hit_cur   = |(eff & cur_oh);
  assign hit_nxt   = |(eff & nxt_oh);
  assign above_cur = |(eff & above_mask(floor_q));
  assign below_cur = |(eff & below_mask(floor_q));
  assign above_nxt = |(eff & above_mask(next_floor));
  assign below_nxt = |(eff & below_mask(next_floor));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      floor_q      <= 3'd0;
      dir_q        <= 1'b1;
      travel_tmr_q <= '0;
      door_tmr_q   <= '0;
      pending_q    <= '0;
    end else begin
      state_q      <= state_d;
      floor_q      <= floor_d;
      dir_q        <= dir_d;
      travel_tmr_q <= travel_tmr_d;
      door_tmr_q   <= door_tmr_d;
      pending_q    <= pending_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    floor_d      = floor_q;
    dir_d        = dir_q;
    travel_tmr_d = travel_tmr_q;
    door_tmr_d   = door_tmr_q;
    clr          = '0;

    case (state_q)
      IDLE: begin
        // Keep sweeping the current way while work remains there, else reverse.
        if (hit_cur) begin
          state_d    = DOOR;
          door_tmr_d = DOOR_LOAD;
          clr        = cur_oh;
        end else if (dir_q && above_cur) begin
          state_d      = MOVE;
          travel_tmr_d = TRAVEL_LOAD;
        end else if (!dir_q && below_cur) begin
          state_d      = MOVE;
          travel_tmr_d = TRAVEL_LOAD;
        end else if (above_cur) begin
          state_d      = MOVE;
          dir_d        = 1'b1;
          travel_tmr_d = TRAVEL_LOAD;
        end else if (below_cur) begin
          state_d      = MOVE;
          dir_d        = 1'b0;
          travel_tmr_d = TRAVEL_LOAD;
        end
      end

      MOVE: begin
        if (travel_tmr_q != '0) begin
          travel_tmr_d = travel_tmr_q - 1'b1;
        end else begin
          floor_d = next_floor;
          if (hit_nxt) begin
            state_d    = DOOR;
            door_tmr_d = DOOR_LOAD;
            clr        = nxt_oh;
          end else if (dir_q ? above_nxt : below_nxt) begin
            travel_tmr_d = TRAVEL_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end

      DOOR: begin
        if (door_tmr_q != '0) begin
          door_tmr_d = door_tmr_q - 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    pending_d = eff & ~clr;
  end

  assign floor     = floor_q;
  assign mux_sig   = dir_q;
  assign moving    = (state_q == MOVE);
  assign door_open = (state_q == DOOR);
  assign pending   = pending_q;

  a_floor_range: assert property (@(posedge clk) disable iff (!rst_n)
    int'(floor_q) < NUM_FLOORS);
  a_dir_held_in_move: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == MOVE) |-> (dir_d == dir_q));

endmodule

// File: tb/tb_elevator_ctrl.sv
// Bench for elevator_ctrl: directed table and sequences plus random requests against a behavioural car model.
module tb_elevator_ctrl;

  localparam int NF     = 8;
  localparam int TRAVEL = 4;
  localparam int DOOR   = 3;

  logic          clk;
  logic          rst_n;
  logic [NF-1:0] req;
  logic [2:0]    next_floor;
  logic [2:0]    floor;
  logic          mux_sig;
  logic          moving;
  logic          door_open;
  logic [NF-1:0] pending;
  bit            clk_run;

  int n_checks;
  int n_errors;
  int cyc;

  elevator_ctrl #(
    .NUM_FLOORS   (NF),
    .TRAVEL_CYCLES(TRAVEL),
    .DOOR_CYCLES  (DOOR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .next_floor(next_floor),
    .floor     (floor),
    .mux_sig   (mux_sig),
    .moving    (moving),
    .door_open (door_open),
    .pending   (pending)
  );

  // External incrementer stage
  assign next_floor = mux_sig ? (floor + 3'd1) : (floor - 3'd1);

  initial begin
    clk = 1'b0;
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural car model ----------------
  int          m_floor;
  bit          m_dir;
  bit          m_moving;
  bit          m_door;
  int          m_elapsed;
  logic [7:0]  m_pend;

  function automatic bit any_above(input logic [7:0] v, input int f);
    for (int i = f + 1; i < NF; i++) if (v[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit any_below(input logic [7:0] v, input int f);
    for (int i = 0; i < f; i++) if (v[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_floor = 0; m_dir = 1'b1; m_moving = 1'b0; m_door = 1'b0;
    m_elapsed = 0; m_pend = '0;
  endtask

  task automatic model_step(input logic [7:0] r);
    logic [7:0] rr;
    logic [7:0] e;
    bit up, dn;
    rr = r;
    if (m_door) rr[m_floor] = 1'b0;
    e = m_pend | rr;
    if (m_moving) begin
      if (m_elapsed < TRAVEL) m_elapsed++;
      else begin
        m_floor = m_dir ? m_floor + 1 : m_floor - 1;
        if (e[m_floor]) begin
          e[m_floor] = 1'b0; m_moving = 1'b0; m_door = 1'b1; m_elapsed = 1;
        end else if (m_dir ? any_above(e, m_floor) : any_below(e, m_floor)) begin
          m_elapsed = 1;
        end else begin
          m_moving = 1'b0;
        end
      end
    end else if (m_door) begin
      if (m_elapsed < DOOR) m_elapsed++;
      else m_door = 1'b0;
    end else begin
      up = any_above(e, m_floor);
      dn = any_below(e, m_floor);
      if (e[m_floor]) begin
        e[m_floor] = 1'b0; m_door = 1'b1; m_elapsed = 1;
      end else if (up && (m_dir || !dn)) begin
        m_dir = 1'b1; m_moving = 1'b1; m_elapsed = 1;
      end else if (dn) begin
        m_dir = 1'b0; m_moving = 1'b1; m_elapsed = 1;
      end
    end
    m_pend = e;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, "_floor"},   32'(floor),     32'(m_floor));
    chk({tag, "_mux"},     32'(mux_sig),   32'(m_dir));
    chk({tag, "_moving"},  32'(moving),    32'(m_moving));
    chk({tag, "_door"},    32'(door_open), 32'(m_door));
    chk({tag, "_pending"}, 32'(pending),   32'(m_pend));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_floor"},   32'(floor),     32'd0);
    chk({tag, "_mux"},     32'(mux_sig),   32'd1);
    chk({tag, "_moving"},  32'(moving),    32'd0);
    chk({tag, "_door"},    32'(door_open), 32'd0);
    chk({tag, "_pending"}, 32'(pending),   32'd0);
  endtask

  // Called at a falling edge; returns at a falling edge.
  task automatic tick(input logic [7:0] r, input string tag);
    req = r;
    @(posedge clk);
    model_step(r);
    @(negedge clk);
    req = '0;
    cyc++;
    cmp_model(tag);
  endtask

  // Per-sequence observations taken from the DUT outputs
  int stops[$];
  int door_cyc[NF];
  int mux_low;
  bit door_prev;

  task automatic rec_clear();
    stops.delete();
    for (int i = 0; i < NF; i++) door_cyc[i] = 0;
    mux_low = 0;
    door_prev = 1'b0;
  endtask

  task automatic tick_rec(input logic [7:0] r, input string tag);
    tick(r, tag);
    if (door_open && !door_prev) stops.push_back(int'(floor));
    if (door_open) door_cyc[floor]++;
    if (!mux_sig) mux_low++;
    door_prev = door_open;
  endtask

  task automatic run_quiet(input string tag, input int budget);
    int n;
    n = 0;
    while ((m_moving || m_door || m_pend != '0) && n < budget) begin
      tick_rec('0, tag);
      n++;
    end
    if (m_moving || m_door || m_pend != '0) begin
      n_checks++; n_errors++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required idle", tag, budget);
    end
    chk({tag, "_idle"}, 32'({moving, door_open}), 32'd0);
  endtask

  task automatic run_until_floor(input string tag, input int f, input int budget);
    int n;
    n = 0;
    while (!(m_floor == f && m_moving) && n < budget) begin
      tick_rec('0, tag);
      n++;
    end
    chk({tag, "_reach"}, 32'(m_floor == f && m_moving), 32'd1);
  endtask

  // Called at a falling edge with the clock running; returns at a falling edge.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk_reset(tag);
    @(posedge clk);
    @(negedge clk);
    chk_reset({tag, "_hold"});
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [7:0] req;
    logic [2:0] floor;
    logic       mux;
    logic       moving;
    logic       door;
    logic [7:0] pend;
  } vec_t;

  vec_t tbl [17];

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0;
    clk_run = 1'b0; rst_n = 1'b1; req = '0;
    model_reset();

    // Single call to floor 3 from floor 0: entry k is the state after edge k.
    for (int k = 0; k < 17; k++) begin
      tbl[k].req    = (k == 0) ? 8'h08 : 8'h00;
      tbl[k].floor  = (k >= 12) ? 3'd3 : 3'(k / 4);
      tbl[k].mux    = 1'b1;
      tbl[k].moving = (k < 12);
      tbl[k].door   = (k >= 12 && k <= 14);
      tbl[k].pend   = (k < 12) ? 8'h08 : 8'h00;
    end

    // Reset with no clock running
    #2 rst_n = 1'b0;
    #1 chk_reset("t1_reset");
    #5 rst_n = 1'b1;
    #1 chk_reset("t1_release");
    clk_run = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 17; k++) begin
      tick(tbl[k].req, "t2_model");
      chk($sformatf("t2_floor_e%0d", k),   32'(floor),     32'(tbl[k].floor));
      chk($sformatf("t2_mux_e%0d", k),     32'(mux_sig),   32'(tbl[k].mux));
      chk($sformatf("t2_moving_e%0d", k),  32'(moving),    32'(tbl[k].moving));
      chk($sformatf("t2_door_e%0d", k),    32'(door_open), 32'(tbl[k].door));
      chk($sformatf("t2_pending_e%0d", k), 32'(pending),   32'(tbl[k].pend));
    end

    // Down to floor 2, then a call for the current floor while idle there
    rec_clear();
    tick_rec(8'h04, "t5_pre");
    run_quiet("t5_pre", 60);
    chk("t5_pre_floor", 32'(floor), 32'd2);
    chk("t5_pre_mux", 32'(mux_sig), 32'd0);
    tick(8'h04, "t5");
    chk("t5_door1", 32'(door_open), 32'd1);
    chk("t5_floor1", 32'(floor), 32'd2);
    chk("t5_moving1", 32'(moving), 32'd0);
    tick(8'h04, "t5");
    chk("t5_door2", 32'(door_open), 32'd1);
    chk("t5_drop_pending", 32'(pending), 32'd0);
    tick('0, "t5");
    chk("t5_door3", 32'(door_open), 32'd1);
    tick('0, "t5");
    chk("t5_door_closed", 32'(door_open), 32'd0);
    chk("t5_moving_end", 32'(moving), 32'd0);
    chk("t5_floor_end", 32'(floor), 32'd2);

    // Intermediate stop picked up on the way up
    async_reset("t3_rst");
    rec_clear();
    tick_rec(8'h40, "t3");
    run_until_floor("t3", 1, 40);
    tick_rec(8'h04, "t3");
    run_quiet("t3", 120);
    chk("t3_nstops", 32'(stops.size()), 32'd2);
    if (stops.size() == 2) begin
      chk("t3_stop0", 32'(stops[0]), 32'd2);
      chk("t3_stop1", 32'(stops[1]), 32'd6);
    end
    chk("t3_door_at2", 32'(door_cyc[2]), 32'(DOOR));
    chk("t3_mux_low", 32'(mux_low), 32'd0);
    chk("t3_floor_end", 32'(floor), 32'd6);

    // Call behind the car is served on the return sweep
    async_reset("t4_rst");
    rec_clear();
    tick_rec(8'h20, "t4");
    run_until_floor("t4", 3, 40);
    tick_rec(8'h02, "t4");
    run_quiet("t4", 150);
    chk("t4_nstops", 32'(stops.size()), 32'd2);
    if (stops.size() == 2) begin
      chk("t4_stop0", 32'(stops[0]), 32'd5);
      chk("t4_stop1", 32'(stops[1]), 32'd1);
    end
    chk("t4_mux_end", 32'(mux_sig), 32'd0);
    chk("t4_floor_end", 32'(floor), 32'd1);
    chk("t4_pending_end", 32'(pending), 32'd0);

    // Asynchronous reset in the middle of a hop
    async_reset("t6_pre");
    rec_clear();
    tick_rec(8'h40, "t6");
    run_until_floor("t6", 4, 60);
    tick_rec('0, "t6");
    chk("t6_pending_mid", 32'(pending), 32'h40);
    async_reset("t6_rst");
    for (int i = 0; i < 10; i++) tick('0, "t6_after");
    chk("t6_floor_after", 32'(floor), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] r;
      r = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
      tick(r, "rnd");
      if ($urandom_range(0, 599) == 0) async_reset("rnd_rst");
    end
    rec_clear();
    run_quiet("rnd_drain", 400);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
